gauss_linebuf_ctrl: RTL and testbench
=====================================

// Module: gauss_linebuf_ctrl
// PURPOSE
//  Line-buffer controller feeding the 3x3 Gaussian sliding window.
//  - Accepts a raster pixel stream and drives two external single-port line RAMs (spram_generic, 1-cycle read, write-through dout).
//  - RAM0 holds row y-1 and RAM1 holds row y-2.
//  - Emits one vertical 3-pixel column per input pixel to the window/column-shift stage.
// PARAMETERS
//  DATA_BITS   8    pixel width; also line-RAM data width
//  ADDR_BITS   7    line-RAM address width
//  IMG_WIDTH   128  pixels per row; must be <= 2**ADDR_BITS
//  ROW_BITS    12   width of row counter m_y
// PORTS
//  clk         in   1          clock, rising edge
//  rst_n       in   1          async active-low reset
//  s_valid     in   1          input pixel valid
//  s_ready     out  1          input pixel accepted when s_valid&s_ready
//  s_sof       in   1          qualifies accepted pixel as frame start (x=0,y=0)
//  s_data      in   DATA_BITS  input pixel
//  ram_en      out  1          enable, shared by both line RAMs
//  ram_we      out  1          write enable, shared
//  ram_addr    out  ADDR_BITS  address, shared (= column x)
//  ram0_din    out  DATA_BITS  RAM0 write data (current pixel)
//  ram1_din    out  DATA_BITS  RAM1 write data (old RAM0 word)
//  ram0_dout   in   DATA_BITS  RAM0 read data
//  ram1_dout   in   DATA_BITS  RAM1 read data
//  m_valid     out  1          one-cycle column strobe
//  m_top       out  DATA_BITS  pixel (x, y-2)
//  m_mid       out  DATA_BITS  pixel (x, y-1)
//  m_bot       out  DATA_BITS  pixel (x, y)
//  m_top_ok    out  1          m_top is real image data (y>=2)
//  m_mid_ok    out  1          m_mid is real image data (y>=1)
//  m_x         out  ADDR_BITS  column of emitted data
//  m_y         out  ROW_BITS   row of emitted data
//  m_eol       out  1          emitted column is last of row (x=IMG_WIDTH-1)
// BEHAVIOUR
//  Reset values:
//  - state=RD, x=0, y=0, s_ready=1.
//  - ram_en=0, ram_we=0, all data/addr outputs 0.
//  - m_valid=0, ok flags 0.
//  - RAM contents are not cleared.
//  FSM, two states; throughput 1 pixel per 2 clocks:
//  - RD: s_ready=1 (combinational from state).
//    - On accept: latch pixel; drive ram_en=1, we=0, addr=x (x forced 0 if s_sof); go WR.
//    - No accept: ram_en=0; stay RD.
//  - WR: s_ready=0; drive ram_en=1, we=1, addr=x, ram0_din=pixel, ram1_din=ram0_dout.
//    - Register m_top=ram1_dout, m_mid=ram0_dout, m_bot=pixel, m_x=x, m_y=y.
//    - Register m_top_ok=(y>=2), m_mid_ok=(y>=1), m_eol=(x==IMG_WIDTH-1).
//    - m_valid=1 on the next clock; go RD.
//  Latency: accept edge -> m_valid high 2 clocks later, held for exactly 1 cycle.
//  Counters advance at end of WR:
//  - x wraps IMG_WIDTH-1 -> 0 and increments y; y saturates at 2**ROW_BITS-1.
//  - s_sof on accept forces x=0, y=0 for that pixel, including mid-row (partial row abandoned).
//  Downstream has no backpressure and must take every m_valid.
//  s_data, s_sof and s_valid are ignored while in WR.
//  Reset asserted mid-operation:
//  - In-flight pixel dropped; no partial write completes after reset.
//  - m_valid does not fire.
// TESTING
//  1. Reset then idle: s_valid=0 for 10 clks -> ram_en=0, m_valid=0, s_ready=1 throughout.
//  2. Single pixel: sof, data=0x5A accepted -> RD addr 0, then WR ram0_din=0x5A; m_valid 2 clks after accept with m_bot=0x5A, m_x=0, m_y=0, ok flags=0.
//  3. IMG_WIDTH=4, stream 12 pixels (value=10*y+x) -> row 2 columns give top=x, mid=10+x, bot=20+x, both ok=1; m_eol at x=3.
//  4. Continuous s_valid=1 -> s_ready toggles 1,0,1,0; exactly one accept per 2 clks; no pixel lost or duplicated.
//  5. s_sof at x=2,y=1 -> that pixel emits m_x=0, m_y=0, ok=0; next pixel m_x=1.
//  6. rst_n low during WR -> ram_we low immediately, no m_valid; after release the first pixel emits m_x=0, m_y=0.

Source files
------------

// File: rtl/gauss_linebuf_ctrl.sv
// rtl/gauss_linebuf_ctrl.sv - line-buffer controller for the 3x3 Gaussian window
// Reads rows y-1 / y-2 from two line RAMs, rotates them, and emits one column per pixel.
module gauss_linebuf_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 7,
  parameter int IMG_WIDTH = 128,
  parameter int ROW_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_sof,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram0_din,
  output logic [DATA_BITS-1:0] ram1_din,
  input  logic [DATA_BITS-1:0] ram0_dout,
  input  logic [DATA_BITS-1:0] ram1_dout,
  output logic                 m_valid,
  output logic [DATA_BITS-1:0] m_top,
  output logic [DATA_BITS-1:0] m_mid,
  output logic [DATA_BITS-1:0] m_bot,
  output logic                 m_top_ok,
  output logic                 m_mid_ok,
  output logic [ADDR_BITS-1:0] m_x,
  output logic [ROW_BITS-1:0]  m_y,
  output logic                 m_eol
);

  localparam logic [ADDR_BITS-1:0] X_LAST = ADDR_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0]  Y_MAX  = '1;

  typedef enum logic {RD = 1'b0, WR = 1'b1} state_t;

  state_t               state, state_nx;
  logic                 accept;
  logic                 wb_pend;
  logic [ADDR_BITS-1:0] x, cx;
  logic [ROW_BITS-1:0]  y, cy;
  logic [DATA_BITS-1:0] pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    accept   = 1'b0;
    case (state)
      RD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          accept   = 1'b1;
          state_nx = WR;
        end
      end
      WR:      state_nx = RD;
      default: state_nx = RD;
    endcase
  end

  // RAM0's old word is only on its dout during the write cycle, so it is forwarded straight to RAM1.
  assign ram1_din = ram_we ? ram0_dout : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram0_din <= '0;
      wb_pend  <= 1'b0;
      x        <= '0;
      y        <= '0;
      cx       <= '0;
      cy       <= '0;
      pix      <= '0;
      m_valid  <= 1'b0;
      m_top    <= '0;
      m_mid    <= '0;
      m_bot    <= '0;
      m_top_ok <= 1'b0;
      m_mid_ok <= 1'b0;
      m_x      <= '0;
      m_y      <= '0;
      m_eol    <= 1'b0;
    end else begin
      ram_en  <= 1'b0;
      ram_we  <= 1'b0;
      wb_pend <= 1'b0;
      m_valid <= 1'b0;

      if (accept) begin
        ram_en   <= 1'b1;
        ram_addr <= s_sof ? '0 : x;
        cx       <= s_sof ? '0 : x;
        cy       <= s_sof ? '0 : y;
        pix      <= s_data;
      end

      if (state == WR) begin
        ram_en   <= 1'b1;
        ram_we   <= 1'b1;
        ram_addr <= cx;
        ram0_din <= pix;
        wb_pend  <= 1'b1;
        if (cx == X_LAST) begin
          x <= '0;
          y <= (cy == Y_MAX) ? cy : cy + 1'b1;
        end else begin
          x <= cx + 1'b1;
          y <= cy;
        end
      end

      // The read data is valid during the write cycle; capture the column as the write lands.
      if (wb_pend) begin
        m_valid  <= 1'b1;
        m_top    <= ram1_dout;
        m_mid    <= ram0_dout;
        m_bot    <= ram0_din;
        m_x      <= cx;
        m_y      <= cy;
        m_top_ok <= (cy >= ROW_BITS'(2));
        m_mid_ok <= (cy != '0);
        m_eol    <= (cx == X_LAST);
      end
    end
  end

endmodule

// File: tb/tb_gauss_linebuf_ctrl.sv
// tb/tb_gauss_linebuf_ctrl.sv - self-checking bench for gauss_linebuf_ctrl
// Column-history reference model with behavioural line RAMs.
module tb_gauss_linebuf_ctrl;
  localparam int DB = 8;
  localparam int AB = 3;
  localparam int W  = 4;
  localparam int RB = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_sof = 1'b0;
  logic [DB-1:0] s_data = '0;
  logic          ram_en, ram_we;
  logic [AB-1:0] ram_addr;
  logic [DB-1:0] ram0_din, ram1_din;
  logic [DB-1:0] ram0_dout, ram1_dout;
  logic          m_valid, m_top_ok, m_mid_ok, m_eol;
  logic [DB-1:0] m_top, m_mid, m_bot;
  logic [AB-1:0] m_x;
  logic [RB-1:0] m_y;

  always #5 clk = ~clk;

  gauss_linebuf_ctrl #(.DATA_BITS(DB), .ADDR_BITS(AB), .IMG_WIDTH(W), .ROW_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_data(s_data), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram0_din(ram0_din), .ram1_din(ram1_din), .ram0_dout(ram0_dout), .ram1_dout(ram1_dout),
    .m_valid(m_valid), .m_top(m_top), .m_mid(m_mid), .m_bot(m_bot), .m_top_ok(m_top_ok),
    .m_mid_ok(m_mid_ok), .m_x(m_x), .m_y(m_y), .m_eol(m_eol)
  );

  // single-port RAMs, 1-cycle read, write-through dout
  logic [DB-1:0] mem0 [0:2**AB-1];
  logic [DB-1:0] mem1 [0:2**AB-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem0[ram_addr] <= ram0_din; ram0_dout <= ram0_din;
        mem1[ram_addr] <= ram1_din; ram1_dout <= ram1_din;
      end else begin
        ram0_dout <= mem0[ram_addr];
        ram1_dout <= mem1[ram_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          sof;
    logic [DB-1:0] d;
    int            c;
  } acc_t;
  acc_t aq[$];

  // model: per-column history of the last two pixels written, plus raster position
  int            mx = 0;
  int            my = 0;
  logic [DB-1:0] h0 [0:W-1];
  logic [DB-1:0] h1 [0:W-1];
  acc_t          mon_a;

  always @(negedge clk) begin
    if (m_valid) begin
      if (aq.size() == 0) begin
        chk("unexpected_m_valid", 32'd1, 32'd0);
      end else begin
        mon_a = aq.pop_front();
        if (mon_a.sof) begin mx = 0; my = 0; end
        chk("latency",  cyc, mon_a.c + 2);
        chk("m_x",      m_x, mx);
        chk("m_y",      m_y, my);
        chk("m_bot",    m_bot, mon_a.d);
        chk("m_mid",    m_mid, h0[mx]);
        chk("m_top",    m_top, h1[mx]);
        chk("m_mid_ok", m_mid_ok, my >= 1);
        chk("m_top_ok", m_top_ok, my >= 2);
        chk("m_eol",    m_eol, mx == W - 1);
        h1[mx] = h0[mx];
        h0[mx] = mon_a.d;
        if (mx == W - 1) begin
          mx = 0;
          if (my < 2**RB - 1) my++;
        end else begin
          mx++;
        end
      end
    end
  end

  task automatic drive_step(input logic v, input logic sof, input logic [DB-1:0] d, output logic took);
    acc_t e;
    @(negedge clk);
    s_valid = v; s_sof = sof; s_data = d;
    took = v && s_ready;
    if (took) begin
      e.sof = sof; e.d = d; e.c = cyc + 1;
      aq.push_back(e);
    end
  endtask

  task automatic send(input logic sof, input logic [DB-1:0] d);
    logic took;
    int   n;
    n = 0;
    do begin
      drive_step(1'b1, sof, d, took);
      n++;
    end while (!took && n < 8);
    if (!took) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic reset_mid(input bool_late);
  endtask

  initial begin
    logic took;
    int   nacc;
    for (int i = 0; i < 2**AB; i++) begin mem0[i] = '0; mem1[i] = '0; end
    for (int i = 0; i < W; i++) begin h0[i] = '0; h1[i] = '0; end
    ram0_dout = '0; ram1_dout = '0;

    // reset state and idle
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, '0);
    chk("rst_ram0_din", ram0_din, '0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_ok", {m_top_ok, m_mid_ok}, 2'b00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ram_en", ram_en, 1'b0);
      chk("idle_m_valid", m_valid, 1'b0);
      chk("idle_s_ready", s_ready, 1'b1);
    end

    // single sof pixel: read cycle then write cycle
    send(1'b1, 8'h5A);
    @(negedge clk);
    chk("p1_rd_en", {ram_en, ram_we}, 2'b10);
    chk("p1_rd_addr", ram_addr, 0);
    chk("p1_busy", s_ready, 1'b0);
    @(negedge clk);
    chk("p1_wr_en", {ram_en, ram_we}, 2'b11);
    chk("p1_wr_din", ram0_din, 8'h5A);
    @(negedge clk);
    chk("p1_m_valid", m_valid, 1'b1);

    // three rows of 10*y+x
    for (int yy = 0; yy < 3; yy++)
      for (int xx = 0; xx < W; xx++)
        send(yy == 0 && xx == 0, DB'(10 * yy + xx));

    // sof in the middle of row 1
    send(1'b1, 8'd100);
    for (int i = 1; i < W + 2; i++) send(1'b0, DB'(100 + i));
    send(1'b1, 8'd200);
    send(1'b0, 8'd201);

    // continuous valid: one accept per two clocks, row counter saturates
    send(1'b1, 8'd7);
    nacc = 0;
    for (int i = 0; i < 80; i++) begin
      drive_step(1'b1, 1'b0, DB'($urandom), took);
      if (took) nacc++;
    end
    drive_step(1'b0, 1'b0, '0, took);
    chk("cont_accepts", nacc, 40);

    // reset during the read cycle, then during the write cycle
    for (int late = 0; late < 2; late++) begin
      repeat (4) @(negedge clk);
      send(1'b0, 8'hE0);
      if (late == 1) begin
        @(posedge clk);
        #1;
      end
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we", ram_we, 1'b0);
      chk("rst_mid_en", ram_en, 1'b0);
      aq.delete();
      mx = 0; my = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2 * W + 1; i++) send(1'b0, DB'($urandom));
    end

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive_step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, DB'($urandom), took);
    drive_step(1'b0, 1'b0, '0, took);

    for (int i = 0; i < 10 && aq.size() != 0; i++) @(negedge clk);
    chk("drain", aq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
